// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: control sequencer for the two-layer MAC datapath.
// It loads input chunks and per-neuron weight chunks from the host stream, walks the
// chunk addresses for the neural engine, and writes each neuron result back.
// Layer-0 results land at L0_OUT_BASE and feed layer 1. Layer-1 results land at 0 and 1
// for the classifier.
// Optional feature: define NNSEQ_PERF_CNT_EN to add the perf_cycles busy-cycle counter.
module nn_layer_sequencer #(
    parameter int LANES       = 20,
    parameter int ADDR_W      = 16,
    parameter int IN_CHUNKS   = 50,
    parameter int L0_NEURONS  = 100,
    parameter int L1_CHUNKS   = 5,
    parameter int L1_NEURONS  = 2,
    parameter int L0_OUT_BASE = 1001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              act_en,
    output logic              act_we,
    output logic [ADDR_W-1:0] act_addr,
    output logic              w_en,
    output logic              w_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic              mac_clr,
    output logic              mac_bias,
    output logic              wb_sel,
    output logic              layer,
    output logic              busy,
    output logic              done
`ifdef NNSEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int CNT_MAX = ((IN_CHUNKS > L0_NEURONS) ? IN_CHUNKS : L0_NEURONS) + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W-1:0] LANES_A = ADDR_W'(LANES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_IN, S_LOAD_W, S_MAC, S_BIAS, S_WRBACK, S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   k_reg, k_next;
    logic [CNT_W-1:0]   n_reg, n_next;
    logic               layer_reg, layer_next;
    logic [CNT_W-1:0]   c_cur, n_max;

    // Registered outputs and their next values
    logic               in_ready_reg, in_ready_next;
    logic               act_en_reg, act_en_next;
    logic               act_we_reg, act_we_next;
    logic [ADDR_W-1:0]  act_addr_reg, act_addr_next;
    logic               w_en_reg, w_en_next;
    logic [ADDR_W-1:0]  w_addr_reg, w_addr_next;
    logic               mac_clr_reg, mac_clr_next;
    logic               mac_bias_reg, mac_bias_next;
    logic               wb_sel_reg, wb_sel_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               hs;
    logic               load_act_wr, load_w_wr;

    assign hs          = in_ready_reg & in_valid;
    assign load_act_wr = hs & (state_reg == S_LOAD_IN);
    assign load_w_wr   = hs & (state_reg == S_LOAD_W);
    assign c_cur       = layer_reg ? CNT_W'(L1_CHUNKS) : CNT_W'(IN_CHUNKS);
    assign n_max       = layer_reg ? CNT_W'(L1_NEURONS) : CNT_W'(L0_NEURONS);

    // State, counters and output registers; active-low synchronous reset aborts any run
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            k_reg        <= '0;
            n_reg        <= '0;
            layer_reg    <= 1'b0;
            in_ready_reg <= 1'b0;
            act_en_reg   <= 1'b0;
            act_we_reg   <= 1'b0;
            act_addr_reg <= '0;
            w_en_reg     <= 1'b0;
            w_addr_reg   <= '0;
            mac_clr_reg  <= 1'b0;
            mac_bias_reg <= 1'b0;
            wb_sel_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            k_reg        <= k_next;
            n_reg        <= n_next;
            layer_reg    <= layer_next;
            in_ready_reg <= in_ready_next;
            act_en_reg   <= act_en_next;
            act_we_reg   <= act_we_next;
            act_addr_reg <= act_addr_next;
            w_en_reg     <= w_en_next;
            w_addr_reg   <= w_addr_next;
            mac_clr_reg  <= mac_clr_next;
            mac_bias_reg <= mac_bias_next;
            wb_sel_reg   <= wb_sel_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Next state and counter update; only the load states wait on the loader
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        n_next     = n_reg;
        layer_next = layer_reg;
        case (state_reg)
            S_IDLE: if (start) begin
                state_next = S_LOAD_IN;
                k_next     = '0;
                n_next     = '0;
                layer_next = 1'b0;
            end
            S_LOAD_IN: if (hs) begin
                if (k_reg == CNT_W'(IN_CHUNKS - 1)) begin
                    state_next = S_LOAD_W;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + CNT_W'(1);
                end
            end
            S_LOAD_W: if (hs) begin
                // C weight chunks followed by the bias chunk at index C
                if (k_reg == c_cur) begin
                    state_next = S_MAC;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + CNT_W'(1);
                end
            end
            S_MAC: begin
                if (k_reg == c_cur - CNT_W'(1)) begin
                    state_next = S_BIAS;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + CNT_W'(1);
                end
            end
            S_BIAS: state_next = S_WRBACK;
            S_WRBACK: begin
                if (n_reg + CNT_W'(1) == n_max) begin
                    n_next = '0;
                    if (!layer_reg) begin
                        layer_next = 1'b1;
                        state_next = S_LOAD_W;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    n_next     = n_reg + CNT_W'(1);
                    state_next = S_LOAD_W;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state and counters
    always_comb begin
        in_ready_next = 1'b0;
        act_en_next   = 1'b0;
        act_we_next   = 1'b0;
        act_addr_next = act_addr_reg;
        w_en_next     = 1'b0;
        w_addr_next   = w_addr_reg;
        mac_clr_next  = 1'b0;
        mac_bias_next = 1'b0;
        wb_sel_next   = 1'b0;
        busy_next     = (state_next != S_IDLE);
        done_next     = 1'b0;
        case (state_next)
            S_LOAD_IN: begin
                in_ready_next = 1'b1;
                act_addr_next = LANES_A * ADDR_W'(k_next);
            end
            S_LOAD_W: begin
                in_ready_next = 1'b1;
                w_addr_next   = LANES_A * ADDR_W'(k_next);
            end
            S_MAC: begin
                act_en_next   = 1'b1;
                act_addr_next = (layer_next ? ADDR_W'(L0_OUT_BASE) : '0) + LANES_A * ADDR_W'(k_next);
                w_en_next     = 1'b1;
                w_addr_next   = LANES_A * ADDR_W'(k_next);
                mac_clr_next  = (k_next == '0);
            end
            S_BIAS: begin
                w_en_next     = 1'b1;
                w_addr_next   = LANES_A * (layer_next ? ADDR_W'(L1_CHUNKS) : ADDR_W'(IN_CHUNKS));
                mac_bias_next = 1'b1;
            end
            S_WRBACK: begin
                act_en_next   = 1'b1;
                act_we_next   = 1'b1;
                act_addr_next = (layer_next ? '0 : ADDR_W'(L0_OUT_BASE)) + ADDR_W'(n_next);
                wb_sel_next   = 1'b1;
            end
            S_DONE: begin
                done_next     = 1'b1;
                act_en_next   = 1'b1;
                act_addr_next = '0;
            end
            default: ;
        endcase
    end

    // Loader writes strobe in the handshake cycle itself so the chunk on the bus is captured
    // at that edge; the address is already registered and waiting.
    assign in_ready = in_ready_reg;
    assign act_en   = act_en_reg | load_act_wr;
    assign act_we   = act_we_reg | load_act_wr;
    assign act_addr = act_addr_reg;
    assign w_en     = w_en_reg | load_w_wr;
    assign w_we     = load_w_wr;
    assign w_addr   = w_addr_reg;
    assign mac_clr  = mac_clr_reg;
    assign mac_bias = mac_bias_reg;
    assign wb_sel   = wb_sel_reg;
    assign layer    = layer_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

`ifdef NNSEQ_PERF_CNT_EN
    logic [31:0] perf_reg;

    // Busy-cycle counter: cleared on an accepted start, saturating, held after done
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            perf_reg <= '0;
        end else if (busy_reg && perf_reg != 32'hFFFF_FFFF) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Testbench for nn_layer_sequencer: the expected memory/engine activity of a whole
// inference is generated from nested layer/neuron/chunk loops and compared cycle by cycle.
module tb_nn_layer_sequencer;

    localparam int ADDR_W = 16;
    localparam int BUDGET = 40000;

    typedef struct packed {
        logic              in_ready;
        logic              act_en;
        logic              act_we;
        logic [ADDR_W-1:0] act_addr;
        logic              w_en;
        logic              w_we;
        logic [ADDR_W-1:0] w_addr;
        logic              mac_clr;
        logic              mac_bias;
        logic              wb_sel;
        logic              layer;
        logic              done;
        logic              busy;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              act_en, act_we, w_en, w_we;
    logic [ADDR_W-1:0] act_addr, w_addr;
    logic              mac_clr, mac_bias, wb_sel, layer, busy, done;
`ifdef NNSEQ_PERF_CNT_EN
    logic [31:0]       perf_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    nn_layer_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .act_en   (act_en),
        .act_we   (act_we),
        .act_addr (act_addr),
        .w_en     (w_en),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .mac_clr  (mac_clr),
        .mac_bias (mac_bias),
        .wb_sel   (wb_sel),
        .layer    (layer),
        .busy     (busy),
        .done     (done)
`ifdef NNSEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    function automatic logic [63:0] outs_vec();
        return 64'({in_ready, act_en, act_we, act_addr, w_en, w_we, w_addr,
                    mac_clr, mac_bias, wb_sel, layer, busy, done});
    endfunction

    function automatic ev_t mk_ev(logic rdy, logic ae, logic awe, int aa, logic we_, logic wwe,
                                  int wa, logic clr, logic bias, logic wb, logic lyr, logic dn);
        ev_t e;
        e.in_ready = rdy;
        e.act_en   = ae;
        e.act_we   = awe;
        e.act_addr = ae ? ADDR_W'(aa) : '0;
        e.w_en     = we_;
        e.w_we     = wwe;
        e.w_addr   = we_ ? ADDR_W'(wa) : '0;
        e.mac_clr  = clr;
        e.mac_bias = bias;
        e.wb_sel   = wb;
        e.layer    = lyr;
        e.done     = dn;
        e.busy     = 1'b1;
        return e;
    endfunction

    function automatic ev_t obs_ev();
        return mk_ev(in_ready, act_en, act_we, int'(act_addr), w_en, w_we, int'(w_addr),
                     mac_clr, mac_bias, wb_sel, layer, done);
    endfunction

    // Reference model: what one inference must do, as an ordered list of busy cycles
    task automatic build_expected();
        int c, nn, ib, ob;
        exp_q.delete();
        for (int k = 0; k < 50; k++)
            exp_q.push_back(mk_ev(1, 1, 1, 20 * k, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int l = 0; l < 2; l++) begin
            c  = (l == 0) ? 50 : 5;
            nn = (l == 0) ? 100 : 2;
            ib = (l == 0) ? 0 : 1001;
            ob = (l == 0) ? 1001 : 0;
            for (int n = 0; n < nn; n++) begin
                for (int k = 0; k <= c; k++)
                    exp_q.push_back(mk_ev(1, 0, 0, 0, 1, 1, 20 * k, 0, 0, 0, l[0], 0));
                for (int k = 0; k < c; k++)
                    exp_q.push_back(mk_ev(0, 1, 0, ib + 20 * k, 1, 0, 20 * k, k == 0, 0, 0, l[0], 0));
                exp_q.push_back(mk_ev(0, 0, 0, 0, 1, 0, 20 * c, 0, 1, 0, l[0], 0));
                exp_q.push_back(mk_ev(0, 1, 1, ob + n, 0, 0, 0, 0, 0, 1, l[0], 0));
            end
        end
        exp_q.push_back(mk_ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    endtask

    // One inference; stall cycles (ready without valid) are skipped against the model
    task automatic run_inference(input bit rand_valid, input bit poke_start,
                                 input bit pre_started, input bit chain_next);
        int  cyc = 0, stalls = 0, total;
        bit  finished = 0;
        ev_t e, o;
        build_expected();
        total = exp_q.size();
        if (!pre_started) begin
            @(negedge clk);
            start    = 1'b1;
            in_valid = 1'b0;
        end
        while (!finished && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start    = poke_start && (exp_q.size() == 1 || (cyc % 997) == 5);
            in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_ready && !in_valid) begin
                stalls++;
                n_checks++;
                if (act_en || w_en) begin
                    n_fail++;
                    $display("FAIL stall_write cyc=%0d act_en=%b w_en=%b required 0/0", cyc, act_en, w_en);
                end
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_cycle cyc=%0d observed=%h required done earlier", cyc, obs_ev());
                finished = 1;
            end else begin
                e = exp_q.pop_front();
                o = obs_ev();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL event idx=%0d cyc=%0d observed=%h required=%h",
                             total - exp_q.size() - 1, cyc, o, e);
                end
                if (e.done) begin
                    finished = 1;
                    n_checks++;
                    if (cyc !== total + stalls) begin
                        n_fail++;
                        $display("FAIL done_latency cyc=%0d required=%0d", cyc, total + stalls);
                    end
                    if (!rand_valid) begin
                        n_checks++;
                        if (cyc !== 10377) begin
                            n_fail++;
                            $display("FAIL done_latency_full cyc=%0d required=10377", cyc);
                        end
                    end
                end
            end
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout cycles=%0d remaining_events=%0d required 0", cyc, exp_q.size());
        end
        // Cycle after DONE: idle, loader bus ignored, start from DONE cycle had no effect
        @(negedge clk);
        start    = chain_next;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || act_en !== 1'b0 || w_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done busy=%b done=%b in_ready=%b act_en=%b w_en=%b required all 0",
                     busy, done, in_ready, act_en, w_en);
        end
`ifdef NNSEQ_PERF_CNT_EN
        n_checks++;
        if (perf_cycles !== 32'(total + stalls)) begin
            n_fail++;
            $display("FAIL perf_cycles observed=%0d required=%0d", perf_cycles, total + stalls);
        end
`endif
        if (!chain_next) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (outs_vec() !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs observed=%h required 0", outs_vec());
        end
`ifdef NNSEQ_PERF_CNT_EN
        n_checks++;
        if (perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf observed=%0d required 0", perf_cycles);
        end
`endif
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset busy=%b in_ready=%b required 0/0", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_mac();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        // cycles 1..50 load inputs, 51..101 load weights, 102.. MAC; cycle 111 is chunk 9
        for (int c = 1; c <= 111; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        n_checks++;
        if (act_en !== 1'b1 || act_we !== 1'b0 || act_addr !== 16'd180 || w_en !== 1'b1 ||
            w_addr !== 16'd180 || mac_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_mac_read act=%b/%b/%0d w=%b/%0d clr=%b required 1/0/180 1/180 0",
                     act_en, act_we, act_addr, w_en, w_addr, mac_clr);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (outs_vec() !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_mac_reset observed=%h required 0", outs_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs_vec() !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_mac_reset_hold observed=%h required 0", outs_vec());
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || act_en !== 1'b0 || w_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_abort busy=%b in_ready=%b act_en=%b w_en=%b required 0",
                     busy, in_ready, act_en, w_en);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_run();
        run_inference(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_valid();
        run_inference(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_inference(1'b0, 1'b1, 1'b0, 1'b1);
        run_inference(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_reset_mid_mac();
        test_full_run();
        test_random_valid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
